pc_gen: RTL and testbench

Fetch-PC generation stage of the hart, directly upstream of the static branch predictor. Holds the fetch PC and issues single-outstanding word requests to the instruction cache. Presents each returned instruction with its PC to the predictor and takes the next PC from the predictor's result in the same cycle. Buffers fetched instructions in a 2-entry queue toward decode and handles execute-stage redirects, including killing an in-flight request.

---
 rtl/pc_gen_pkg.sv | 34 +++
 rtl/pc_gen_fetch_fifo.sv | 64 ++++++
 rtl/pc_gen.sv | 126 ++++++++++++
 tb/tb_pc_gen.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_pkg
// Brief    : Shared hart header: reset PC, RV opcode constants, pc_gen state
//            encodings and the fetch-queue entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

  localparam logic [63:0] C_RESET_PC   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] C_ALIGN_MASK = ~64'd3;

  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;

  // Fetch state machine encodings
  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_REQ  = 2'd1;
  localparam logic [1:0] C_ST_DROP = 2'd2;

  // One queued fetch toward decode
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ir;
    logic        pred;
  } fetch_entry_t;

  // Sign-extend the predictor's 13-bit branch offset to a full PC width
  function automatic logic [63:0] sext_offs13(input logic [12:0] offs);
    return {{51{offs[12]}}, offs};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : 2-entry synchronous FIFO of {pc, ir, pred} between fetch and
//            decode. Entry 0 is always the head; flush empties the queue.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import pc_gen_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  fetch_entry_t ent0_q;
  fetch_entry_t ent1_q;
  logic [1:0]   cnt_q;

  // Shift-style storage: pops move entry 1 into the head slot
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else if (flush_i) begin
      cnt_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= din_i;
          else               ent1_q <= din_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever remains
          if (cnt_q == 2'd1) begin
            ent0_q <= din_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = ent0_q;
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch-PC generation. Single-outstanding I$ requests, same-cycle
//            next-PC from the static predictor, 2-entry queue to decode,
//            execute redirects with in-flight request kill.
// Config   : BPU_PRED_EN - when defined, conditional-branch predictions steer
//            the fetch PC and mark if_pred; JAL steering is always on.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [63:0] RESET_PC = C_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ic_req,
  output logic [63:0] ic_addr,
  input  logic        ic_ack,
  input  logic [31:0] ic_data,
  output logic [63:0] bp_pc,
  output logic [31:0] bp_ir,
  input  logic        jal_taken,
  input  logic [63:0] jal_addr,
  input  logic        pr_taken,
  input  logic [12:0] pr_offs,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_ir,
  output logic        if_pred,
  input  logic        if_ready,
  input  logic        ex_redir,
  input  logic [63:0] ex_addr
);

  logic [1:0]   state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic         live_beat;
  logic         pop;
  logic         br_taken;
  logic [1:0]   fifo_cnt;
  logic [1:0]   post_cnt;
  fetch_entry_t push_ent;
  fetch_entry_t head_ent;

  assign ic_req  = (state_q != C_ST_IDLE);
  assign ic_addr = fetch_pc_q;
  assign bp_pc   = fetch_pc_q;
  assign bp_ir   = ic_data;

`ifdef BPU_PRED_EN
  assign br_taken = pr_taken;
`else
  logic unused_pr_taken;
  assign unused_pr_taken = pr_taken;
  assign br_taken        = 1'b0;
`endif

  // Only a beat for a request that was not killed, and not hit by a redirect
  assign live_beat = (state_q == C_ST_REQ) && ic_ack && !ex_redir;
  assign pop       = if_valid && if_ready && !ex_redir;
  assign post_cnt  = fifo_cnt + {1'b0, live_beat} - {1'b0, pop};

  assign push_ent = '{pc: fetch_pc_q, ir: ic_data, pred: jal_taken || br_taken};

  // Next fetch PC: redirect, then JAL, then predicted branch, then sequential
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (ex_redir) begin
      fetch_pc_d = ex_addr & C_ALIGN_MASK;
    end else if (live_beat) begin
      if (jal_taken)     fetch_pc_d = jal_addr & C_ALIGN_MASK;
      else if (br_taken) fetch_pc_d = (fetch_pc_q + sext_offs13(pr_offs)) & C_ALIGN_MASK;
      else               fetch_pc_d = fetch_pc_q + 64'd4;
    end
  end

  // Request state: issue only when the queue is guaranteed space for the beat
  always_comb begin
    state_d = state_q;
    if (ex_redir) begin
      case (state_q)
        C_ST_REQ:  state_d = ic_ack ? C_ST_REQ : C_ST_DROP;
        C_ST_DROP: state_d = C_ST_DROP;
        default:   state_d = C_ST_REQ;
      endcase
    end else begin
      case (state_q)
        C_ST_IDLE: if (post_cnt < 2'd2) state_d = C_ST_REQ;
        C_ST_REQ:  if (ic_ack) state_d = (post_cnt < 2'd2) ? C_ST_REQ : C_ST_IDLE;
        C_ST_DROP: if (ic_ack) state_d = C_ST_REQ;
        default:   state_d = C_ST_IDLE;
      endcase
    end
  end

  // State and fetch PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= C_ST_IDLE;
      fetch_pc_q <= RESET_PC & C_ALIGN_MASK;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (live_beat),
    .pop_i   (pop),
    .flush_i (ex_redir),
    .din_i   (push_ent),
    .head_o  (head_ent),
    .valid_o (if_valid),
    .count_o (fifo_cnt)
  );

  assign if_pc   = head_ent.pc;
  assign if_ir   = head_ent.ir;
  assign if_pred = head_ent.pred;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Self-checking bench for pc_gen: directed fetch scenarios then
//            randomized cache/decode/redirect traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JAL100 = 32'h1000_006F;   // jal x0, +0x100
  localparam logic [31:0] BRM8   = 32'hFE00_0CE3;   // beq x0, x0, -8
  localparam logic [6:0]  OP_JAL = 7'b1101111;
  localparam logic [6:0]  OP_BR  = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [63:0] ic_addr;
  logic        ic_ack;
  logic [31:0] ic_data;
  logic [63:0] bp_pc;
  logic [31:0] bp_ir;
  logic        jal_taken;
  logic [63:0] jal_addr;
  logic        pr_taken;
  logic [12:0] pr_offs;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_ir;
  logic        if_pred;
  logic        if_ready;
  logic        ex_redir;
  logic [63:0] ex_addr;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack),
    .ic_data(ic_data), .bp_pc(bp_pc), .bp_ir(bp_ir), .jal_taken(jal_taken),
    .jal_addr(jal_addr), .pr_taken(pr_taken), .pr_offs(pr_offs),
    .if_valid(if_valid), .if_pc(if_pc), .if_ir(if_ir), .if_pred(if_pred),
    .if_ready(if_ready), .ex_redir(ex_redir), .ex_addr(ex_addr)
  );

  function automatic logic [63:0] jimm(input logic [31:0] ir);
    return {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  function automatic logic [63:0] bimm(input logic [31:0] ir);
    return {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  // Static predictor stand-in: JAL always, backward branches taken
  always_comb begin
    jal_taken = (bp_ir[6:0] == OP_JAL);
    jal_addr  = bp_pc + jimm(bp_ir);
    pr_taken  = (bp_ir[6:0] == OP_BR) && bp_ir[31];
    pr_offs   = {bp_ir[31], bp_ir[7], bp_ir[30:25], bp_ir[11:8], 1'b0};
  end

  // Reference model: fetch PC, request/kill flags and the decode queue
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ir;
    logic        pred;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_pc;
  bit          m_req;
  bit          m_kill;
  int          n_checks = 0;
  int          n_errors = 0;
  int          lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    chk("ic_req", ic_req, m_req);
    chk("ic_addr", ic_addr, m_pc);
    chk("bp_pc", bp_pc, m_pc);
    chk("bp_ir", bp_ir, ic_data);
    chk("if_valid", if_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("if_pc", if_pc, m_q[0].pc);
      chk("if_ir", if_ir, m_q[0].ir);
      chk("if_pred", if_pred, m_q[0].pred);
    end
  endtask

  task automatic model_step();
    bit   beat, is_jal, is_br;
    ent_t e;
    beat = m_req && ic_ack;
    if (ex_redir) begin
      if (!m_kill) m_kill = m_req && !ic_ack;
      m_req = 1'b1;
      m_q.delete();
      m_pc = ex_addr & ~64'd3;
    end else if (beat && m_kill) begin
      m_kill = 1'b0;
    end else begin
      if (if_ready && m_q.size() != 0) m_q.delete(0);
      if (beat) begin
        is_jal = (ic_data[6:0] == OP_JAL);
`ifdef BPU_PRED_EN
        is_br = (ic_data[6:0] == OP_BR) && ic_data[31];
`else
        is_br = 1'b0;
`endif
        e.pc   = m_pc;
        e.ir   = ic_data;
        e.pred = is_jal || is_br;
        m_q.push_back(e);
        if (is_jal)     m_pc = (m_pc + jimm(ic_data)) & ~64'd3;
        else if (is_br) m_pc = (m_pc + bimm(ic_data)) & ~64'd3;
        else            m_pc = m_pc + 64'd4;
      end
      if (!m_req || beat) m_req = (m_q.size() < 2);
    end
  endtask

  // One clock: check at the falling edge, advance the model, end just after rise
  task automatic cyc();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic ack, input logic [31:0] data, input logic rdy,
                     input logic redir, input logic [63:0] addr);
    ic_ack   = ack;
    ic_data  = data;
    if_ready = rdy;
    ex_redir = redir;
    ex_addr  = addr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(1'b0, NOP, 1'b0, 1'b0, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    m_pc   = RST_PC;
    m_req  = 1'b0;
    m_kill = 1'b0;
    m_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r32a, r32b;
    logic [63:0] exp_pc;
    logic        exp_pred;
    bit          ack_now;

    // Reset values and first sequential fetches
    do_reset();
    chk("rst_ic_req", ic_req, 1'b0);
    chk("rst_ic_addr", ic_addr, RST_PC);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 64'd0);
    chk("rst_if_ir", if_ir, 32'd0);
    chk("rst_if_pred", if_pred, 1'b0);
    drv(1'b0, NOP, 1'b1, 1'b0, 64'd0); cyc();
    chk("first_req", ic_req, 1'b1);
    chk("first_addr", ic_addr, 64'h8000_0000);
    drv(1'b1, NOP, 1'b1, 1'b0, 64'd0); cyc();
    chk("seq_addr4", ic_addr, 64'h8000_0004);
    chk("seq_req_b2b", ic_req, 1'b1);
    chk("seq_ifpc0", if_pc, 64'h8000_0000);
    drv(1'b0, NOP, 1'b1, 1'b0, 64'd0); cyc();
    drv(1'b1, NOP, 1'b1, 1'b0, 64'd0); cyc();
    chk("seq_addr8", ic_addr, 64'h8000_0008);
    chk("seq_ifpc4", if_pc, 64'h8000_0004);

    // JAL +0x100 returned at 8000_0004
    do_reset();
    drv(1'b0, NOP, 1'b1, 1'b0, 64'd0); cyc();
    drv(1'b1, NOP, 1'b1, 1'b0, 64'd0); cyc();
    drv(1'b0, NOP, 1'b1, 1'b0, 64'd0); cyc();
    drv(1'b1, JAL100, 1'b1, 1'b0, 64'd0); cyc();
    chk("jal_addr", ic_addr, 64'h8000_0104);
    chk("jal_ifpc", if_pc, 64'h8000_0004);
    chk("jal_pred", if_pred, 1'b1);
    chk("jal_ir", if_ir, JAL100);

    // Backward branch at 8000_0010
    do_reset();
    drv(1'b0, NOP, 1'b1, 1'b0, 64'd0); cyc();
    repeat (4) begin drv(1'b1, NOP, 1'b1, 1'b0, 64'd0); cyc(); end
    drv(1'b1, BRM8, 1'b1, 1'b0, 64'd0); cyc();
`ifdef BPU_PRED_EN
    exp_pc = 64'h8000_0008; exp_pred = 1'b1;
`else
    exp_pc = 64'h8000_0014; exp_pred = 1'b0;
`endif
    chk("br_addr", ic_addr, exp_pc);
    chk("br_ifpc", if_pc, 64'h8000_0010);
    chk("br_pred", if_pred, exp_pred);

    // Decode backpressure: two entries, then request stops until a pop
    do_reset();
    drv(1'b0, NOP, 1'b0, 1'b0, 64'd0); cyc();
    drv(1'b1, NOP, 1'b0, 1'b0, 64'd0); cyc();
    drv(1'b1, NOP, 1'b0, 1'b0, 64'd0); cyc();
    chk("full_req", ic_req, 1'b0);
    chk("full_head", if_pc, 64'h8000_0000);
    chk("full_addr", ic_addr, 64'h8000_0008);
    repeat (3) begin
      drv(1'b0, NOP, 1'b0, 1'b0, 64'd0); cyc();
      chk("full_hold_req", ic_req, 1'b0);
    end
    drv(1'b0, NOP, 1'b1, 1'b0, 64'd0); cyc();
    chk("resume_req", ic_req, 1'b1);
    chk("resume_head", if_pc, 64'h8000_0004);

    // Redirect with an outstanding request; ack arrives 3 cycles later
    do_reset();
    drv(1'b0, NOP, 1'b0, 1'b0, 64'd0); cyc();
    drv(1'b1, NOP, 1'b0, 1'b0, 64'd0); cyc();
    drv(1'b0, NOP, 1'b1, 1'b1, 64'h8000_0200); cyc();
    chk("kill_flush", if_valid, 1'b0);
    chk("kill_addr", ic_addr, 64'h8000_0200);
    chk("kill_req", ic_req, 1'b1);
    repeat (2) begin
      drv(1'b0, NOP, 1'b1, 1'b0, 64'd0); cyc();
      chk("kill_empty", if_valid, 1'b0);
    end
    drv(1'b1, JAL100, 1'b1, 1'b0, 64'd0); cyc();
    chk("kill_discard", if_valid, 1'b0);
    chk("kill_addr_hold", ic_addr, 64'h8000_0200);
    drv(1'b1, NOP, 1'b1, 1'b0, 64'd0); cyc();
    chk("kill_next_pc", if_pc, 64'h8000_0200);
    chk("kill_next_addr", ic_addr, 64'h8000_0204);

    // Redirect coinciding with ack, then a redirect to the top of memory
    do_reset();
    drv(1'b0, NOP, 1'b1, 1'b0, 64'd0); cyc();
    drv(1'b1, NOP, 1'b1, 1'b1, 64'h8000_0302); cyc();
    chk("redir_ack_addr", ic_addr, 64'h8000_0300);
    chk("redir_ack_valid", if_valid, 1'b0);
    drv(1'b1, NOP, 1'b1, 1'b0, 64'd0); cyc();
    chk("redir_ack_pc", if_pc, 64'h8000_0300);
    drv(1'b0, NOP, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE); cyc();
    drv(1'b1, NOP, 1'b1, 1'b0, 64'd0); cyc();
    drv(1'b1, NOP, 1'b1, 1'b0, 64'd0); cyc();
    chk("wrap_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", ic_addr, 64'd0);

    // Randomized traffic
    do_reset();
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        lat = 0;
      end
      r32a = $urandom();
      r32b = $urandom();
      case ($urandom_range(0, 3))
        0:       ic_data = {r32a[31:7], OP_JAL};
        1:       ic_data = {r32a[31:7], OP_BR};
        default: ic_data = r32a;
      endcase
      ic_ack   = m_req && (lat == 0);
      if_ready = ($urandom_range(0, 2) != 0);
      ex_redir = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) ex_addr = {32'hFFFF_FFFF, 24'hFF_FFFF, r32b[7:0]};
      else                           ex_addr = {r32b, $urandom()};
      ack_now = ic_ack;
      cyc();
      if (ack_now)      lat = $urandom_range(0, 3);
      else if (lat > 0) lat--;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
